// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding,
// default operand width and the iteration counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 4;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/trial_sub.sv
// Combinational N-bit borrow-ripple subtractor (d = a - b - bin) built
// from per-bit full-subtractor equations.
module trial_sub #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] d,
    output logic         bout
);

    always_comb begin
        logic [N:0] br;
        d     = '0;
        br    = '0;
        br[0] = bin;
        for (int unsigned i = 0; i < N; i++) begin
            d[i]    = a[i] ^ b[i] ^ br[i];
            br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
        end
        bout = br[N];
    end

endmodule

// File: rtl/restoring_div4.sv
// Sequential restoring divider with start/done handshake, one trial
// subtraction per cycle. Optional macro EARLY_EXIT_EN skips iterating when dividend < divisor.
module restoring_div4
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state, state_next;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    count;

    logic             accept;
    logic             last;
    logic             zero_div;
    logic             early;
    logic [WIDTH:0]   s_val;
    logic [WIDTH:0]   t_val;
    logic             borrow;
    logic             qbit;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH:0]   r_next;

    assign zero_div = (divisor == '0);

`ifdef EARLY_EXIT_EN
    assign early = !zero_div && (dividend < divisor);
`else
    assign early = 1'b0;
`endif

    assign s_val = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    trial_sub #(
        .N(WIDTH + 1)
    ) u_trial_sub (
        .a   (s_val),
        .b   ({1'b0, d_reg}),
        .bin (1'b0),
        .d   (t_val),
        .bout(borrow)
    );

    always_comb begin
        qbit   = ~borrow;
        q_next = {q_reg[WIDTH-2:0], qbit};
        r_next = borrow ? s_val : t_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (zero_div || early) ? S_DONE : S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (count == CW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Zero-divisor and early-exit results are produced at the accepting edge,
    // so their done pulse coincides with the single DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg       <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                d_reg       <= divisor;
                q_reg       <= dividend;
                r_reg       <= '0;
                count       <= '0;
                div_by_zero <= 1'b0;
                if (zero_div) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end else if (early) begin
                    quotient  <= '0;
                    remainder <= dividend;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end else begin
                    busy <= 1'b1;
                end
            end else if (state == S_RUN) begin
                r_reg <= r_next;
                q_reg <= q_next;
                count <= count + CW'(1);
                if (last) begin
                    quotient  <= q_next;
                    remainder <= r_next[WIDTH-1:0];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
            end
        end
    end

    // The restored/accepted partial remainder is always below the divisor.
    always_comb begin
        if (!rst) assert (r_reg[WIDTH] == 1'b0);
    end

endmodule

// File: tb/tb_restoring_div4.sv
// Scoreboard bench for restoring_div4: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done is presented.
module tb_restoring_div4;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    restoring_div4 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int unsigned  cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

`ifdef EARLY_EXIT_EN
    localparam int unsigned SMALL_LAT = 0;
`else
    localparam int unsigned SMALL_LAT = W;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending result", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (quotient !== e.q) begin
                    errors++;
                    $display("FAIL quotient: got %0d, required %0d", quotient, e.q);
                end
                checks++;
                if (remainder !== e.r) begin
                    errors++;
                    $display("FAIL remainder: got %0d, required %0d", remainder, e.r);
                end
                checks++;
                if (div_by_zero !== e.z) begin
                    errors++;
                    $display("FAIL div_by_zero: got %0d, required %0d", div_by_zero, e.z);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL done_latency: done at cycle %0d, required %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Call at a negedge; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez, input int unsigned lat, input bit expect_result);
        exp_t e;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        if (expect_result) begin
            e.q   = eq;
            e.r   = er;
            e.z   = ez;
            e.cyc = cyc + lat;
            sb.push_back(e);
        end
        start = 1'b0;
    endtask

    // Returns at the negedge where done is seen; exp_busy < 0 skips the busy count check.
    task automatic wait_done(input string name, input int exp_busy);
        int  nb = 0;
        bit  seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: done not seen within 30 cycles, required done", name);
        end
        if (exp_busy >= 0) check({name, "_busy_cycles"}, nb, exp_busy);
        #1;
        check({name, "_pending"}, sb.size(), 0);
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ez, input int unsigned lat, input string name);
        issue(a, b, eq, er, ez, lat, 1'b1);
        wait_done(name, int'(lat));
    endtask

    initial begin
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, W, "div_13_4");

        // back-to-back: start held through the DONE cycle of 15/1
        @(negedge clk);
        issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, W, 1'b1);
        wait_done("div_15_1", W);
        issue(4'd9, 4'd3, 4'd3, 4'd0, 1'b0, W, 1'b1);
        wait_done("div_9_3", W);

        @(negedge clk);
        run(4'd7, 4'd0, 4'hF, 4'd7, 1'b1, 0, "div_7_0");
        @(negedge clk);
        run(4'd2, 4'd9, 4'd0, 4'd2, 1'b0, SMALL_LAT, "div_2_9");
        @(negedge clk);
        run(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, W, "div_15_15");
        @(negedge clk);
        run(4'd10, 4'd7, 4'd1, 4'd3, 1'b0, W, "div_10_7");
        @(negedge clk);
        run(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, SMALL_LAT, "div_0_5");
        @(negedge clk);
        run(4'd15, 4'd2, 4'd7, 4'd1, 1'b0, W, "div_15_2");
        @(negedge clk);
        run(4'd8, 4'd3, 4'd2, 4'd2, 1'b0, W, "div_8_3");

        // start pulse while busy must be ignored
        @(negedge clk);
        issue(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, W, 1'b1);
        @(negedge clk);
        check("busy_in_run", busy, 1);
        issue(4'd5, 4'd5, 4'd0, 4'd0, 1'b0, 0, 1'b0);
        dividend = '0;
        divisor  = '0;
        wait_done("div_14_3", -1);
        repeat (8) @(negedge clk);

        // async reset mid-run
        issue(4'd11, 4'd2, 4'd0, 4'd0, 1'b0, 0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_done", done, 0);
        check("midrun_rst_quotient", quotient, 0);
        check("midrun_rst_remainder", remainder, 0);
        check("midrun_rst_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("no_done_after_rst", sb.size(), 0);
        run(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, W, "div_11_2");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
